// File: rtl/scene_loader_pkg.sv
// Shared types and constants for the scene loader.
// Word address helper maps a byte pair index onto SRAM.
package scene_loader_pkg;

    typedef enum logic [1:0] {
        SL_IDLE,
        SL_LOAD,
        SL_FLUSH,
        SL_DONE
    } sl_state_t;

    localparam logic [19:0] SCENE_BASE_ADDR = 20'h0;
    localparam int          SL_FIFO_DEPTH   = 4;
    localparam int          SL_WORD_W       = 36;

    function automatic logic [19:0] sl_word_addr(
        input logic [19:0] base,
        input logic [14:0] widx
    );
        return base + {5'd0, widx};
    endfunction

endpackage

// File: rtl/sl_word_fifo.sv
// Small write-word FIFO: {addr, data} entries, head is combinational.
// A push into a full FIFO succeeds only when a pop frees the slot.
module sl_word_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 36
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]  PTR_ONE  = 1;
    localparam logic [AW:0]    CNT_ONE  = 1;
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_q];

    // Storage array; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PTR_ONE;
            if (do_pop)  rd_q <= rd_q + PTR_ONE;
            if (do_push && !do_pop)      cnt_q <= cnt_q + CNT_ONE;
            else if (do_pop && !do_push) cnt_q <= cnt_q - CNT_ONE;
        end
    end

endmodule

// File: rtl/scene_loader.sv
// Packs XMODEM scene bytes into 16-bit SRAM words via a small FIFO.
// Bad blocks rewind the byte index to the start of the block.
module scene_loader
    import scene_loader_pkg::*;
#(
    parameter logic [19:0] BASE_ADDR  = SCENE_BASE_ADDR,
    parameter int          FIFO_DEPTH = SL_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [7:0]  xmodem_data_byte,
    input  logic        xmodem_saw_valid_msg_byte,
    input  logic        xmodem_saw_valid_block,
    input  logic        xmodem_receiving_repeat_block,
    input  logic        xmodem_saw_invalid_block,
    input  logic        xmodem_done,
    output logic [7:0]  sl_block_num,
    output logic        sl_we,
    output logic [19:0] sl_addr,
    output logic [15:0] sl_data,
    input  logic        sl_stall,
    output logic [15:0] sl_byte_cnt,
    output logic        scene_loaded,
    output logic        sl_overflow
);

    sl_state_t            state_q;
    logic [15:0]          cnt_q;
    logic [15:0]          blk_cnt_q;
    logic [7:0]           pack_q;
    logic [7:0]           blk_num_q;
    logic                 loaded_q;
    logic                 ovf_q;

    logic                 in_idle;
    logic                 in_load;
    logic                 in_flush;
    logic                 in_done;
    logic                 accept;
    logic                 take;
    logic [15:0]          idx;
    logic                 push;
    logic [SL_WORD_W-1:0] push_word;
    logic                 pop;
    logic                 ovf_set;
    logic [SL_WORD_W-1:0] head;
    logic                 full;
    logic                 empty;

    assign in_idle  = (state_q == SL_IDLE);
    assign in_load  = (state_q == SL_LOAD);
    assign in_flush = (state_q == SL_FLUSH);
    assign in_done  = (state_q == SL_DONE);

    assign accept = xmodem_saw_valid_msg_byte && !xmodem_receiving_repeat_block;
    assign take   = accept && ((in_idle && !xmodem_done)
                  || (in_load && !xmodem_done && !xmodem_saw_invalid_block)
                  || in_done);
    // A new scene out of DONE starts again at byte 0.
    assign idx    = in_done ? 16'd0 : cnt_q;

    // Odd bytes complete a word; EOT flushes a lone trailing byte.
    always_comb begin
        push      = 1'b0;
        push_word = '0;
        if (in_load && xmodem_done && cnt_q[0]) begin
            push      = 1'b1;
            push_word = {sl_word_addr(BASE_ADDR, cnt_q[15:1]), 8'h00, pack_q};
        end else if (take && idx[0]) begin
            push      = 1'b1;
            push_word = {sl_word_addr(BASE_ADDR, idx[15:1]),
                         xmodem_data_byte, pack_q};
        end
    end

    assign pop     = !empty && !sl_stall;
    assign ovf_set = push && full && !pop;

    sl_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (SL_WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_b (rst_b),
        .push  (push),
        .din   (push_word),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // Scene FSM with byte counting, block rewind and status flags.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= SL_IDLE;
            cnt_q     <= '0;
            blk_cnt_q <= '0;
            pack_q    <= '0;
            blk_num_q <= '0;
            loaded_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (ovf_set) ovf_q <= 1'b1;
            if (take) begin
                cnt_q <= idx + 16'd1;
                if (!idx[0]) pack_q <= xmodem_data_byte;
                if (xmodem_saw_valid_block) begin
                    blk_num_q <= (in_done ? 8'd0 : blk_num_q) + 8'd1;
                    blk_cnt_q <= idx;
                end else if (in_done) begin
                    blk_num_q <= '0;
                    blk_cnt_q <= '0;
                end
            end
            unique case (1'b1)
                in_idle: begin
                    if (xmodem_done) begin
                        state_q  <= SL_DONE;
                        loaded_q <= 1'b1;
                    end else if (take) begin
                        state_q <= SL_LOAD;
                    end
                end
                in_load: begin
                    if (xmodem_done) begin
                        state_q <= SL_FLUSH;
                    end else if (xmodem_saw_invalid_block) begin
                        cnt_q  <= blk_cnt_q;
                        pack_q <= '0;
                    end
                end
                in_flush: begin
                    if (empty) begin
                        state_q  <= SL_DONE;
                        loaded_q <= 1'b1;
                    end
                end
                in_done: begin
                    if (take) begin
                        state_q  <= SL_LOAD;
                        loaded_q <= 1'b0;
                        ovf_q    <= 1'b0;
                    end
                end
                default: state_q <= SL_IDLE;
            endcase
        end
    end

    assign sl_we        = !empty;
    assign sl_addr      = empty ? 20'h0 : head[35:16];
    assign sl_data      = empty ? 16'h0 : head[15:0];
    assign sl_block_num = blk_num_q;
    assign sl_byte_cnt  = cnt_q;
    assign scene_loaded = loaded_q;
    assign sl_overflow  = ovf_q;

endmodule

// File: tb/tb_scene_loader.sv
// Directed bench for scene_loader: packing, flush, overflow,
// repeat/invalid blocks and mid-load reset.
module tb_scene_loader;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [7:0]  data_b = '0;
    logic        valid = 1'b0;
    logic        vblk = 1'b0;
    logic        rep = 1'b0;
    logic        inv = 1'b0;
    logic        done = 1'b0;
    logic        stall = 1'b0;
    logic [7:0]  blk_num;
    logic        we;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] byte_cnt;
    logic        loaded;
    logic        ovf;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [35:0] wlog[$];

    scene_loader dut (
        .clk                           (clk),
        .rst_b                         (rst_b),
        .xmodem_data_byte              (data_b),
        .xmodem_saw_valid_msg_byte     (valid),
        .xmodem_saw_valid_block        (vblk),
        .xmodem_receiving_repeat_block (rep),
        .xmodem_saw_invalid_block      (inv),
        .xmodem_done                   (done),
        .sl_block_num                  (blk_num),
        .sl_we                         (we),
        .sl_addr                       (addr),
        .sl_data                       (wdata),
        .sl_stall                      (stall),
        .sl_byte_cnt                   (byte_cnt),
        .scene_loaded                  (loaded),
        .sl_overflow                   (ovf)
    );

    always #5 clk = ~clk;

    // Inputs change just after posedge, so negedge sees the pop decision.
    always @(negedge clk) begin
        if (rst_b && we && !stall) wlog.push_back({addr, wdata});
    end

    task automatic chk(input string tag, input logic [35:0] got,
                       input logic [35:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] wl(input int i);
        if (i < wlog.size()) return wlog[i];
        return '1;
    endfunction

    task automatic drive(input logic [7:0] b, input logic v, input logic vb,
                         input logic r, input logic iv, input logic dn);
        @(posedge clk);
        #1;
        data_b = b; valid = v; vblk = vb; rep = r; inv = iv; done = dn;
    endtask

    task automatic send(input logic [7:0] b, input logic vb);
        drive(b, 1'b1, vb, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_b = 1'b0; stall = 1'b0;
        data_b = '0; valid = 0; vblk = 0; rep = 0; inv = 0; done = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;
        wlog.delete();
    endtask

    initial begin
        // Reset values
        do_reset();
        chk("rst_we", 36'(we), 36'd0);
        chk("rst_addr", 36'(addr), 36'd0);
        chk("rst_data", 36'(wdata), 36'd0);
        chk("rst_cnt", 36'(byte_cnt), 36'd0);
        chk("rst_blk", 36'(blk_num), 36'd0);
        chk("rst_flags", 36'({loaded, ovf}), 36'd0);

        // Empty scene: done straight from IDLE
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("empty_loaded", 36'(loaded), 36'd1);
        chk("empty_we", 36'(we), 36'd0);

        // Four bytes, one per cycle
        do_reset();
        send(8'h11, 1'b1);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        chk("lat_we", 36'(we), 36'd1);
        chk("lat_word", {addr, wdata}, {20'd0, 16'h2211});
        send(8'h44, 1'b0);
        idle(6);
        chk("p4_nw", 36'(wlog.size()), 36'd2);
        chk("p4_w0", wl(0), {20'd0, 16'h2211});
        chk("p4_w1", wl(1), {20'd1, 16'h4433});
        chk("p4_cnt", 36'(byte_cnt), 36'd4);
        chk("p4_blk", 36'(blk_num), 36'd1);

        // Odd byte count then EOT
        do_reset();
        send(8'hAA, 1'b1);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(6);
        chk("odd_nw", 36'(wlog.size()), 36'd2);
        chk("odd_w0", wl(0), {20'd0, 16'hBBAA});
        chk("odd_w1", wl(1), {20'd1, 16'h00CC});
        chk("odd_loaded", 36'(loaded), 36'd1);
        chk("odd_cnt", 36'(byte_cnt), 36'd3);
        // New scene restarts from DONE
        send(8'h55, 1'b0);
        idle(2);
        chk("rs_loaded", 36'(loaded), 36'd0);
        chk("rs_cnt", 36'(byte_cnt), 36'd1);
        chk("rs_blk", 36'(blk_num), 36'd0);

        // Overflow under stall
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 12; i++) send(8'(8'h10 + i), i == 0);
        idle(8);
        chk("ov_flag", 36'(ovf), 36'd1);
        chk("ov_nw_stall", 36'(wlog.size()), 36'd0);
        chk("ov_we", 36'(we), 36'd1);
        stall = 1'b0;
        idle(8);
        chk("ov_nw", 36'(wlog.size()), 36'd4);
        chk("ov_w0", wl(0), {20'd0, 16'h1110});
        chk("ov_w1", wl(1), {20'd1, 16'h1312});
        chk("ov_w2", wl(2), {20'd2, 16'h1514});
        chk("ov_w3", wl(3), {20'd3, 16'h1716});

        // Full block then a repeated block
        do_reset();
        for (int i = 0; i < 128; i++) send(8'(i), i == 0);
        for (int i = 0; i < 5; i++)
            drive(8'hEE, 1'b1, i == 0, 1'b1, 1'b0, 1'b0);
        idle(6);
        chk("b1_nw", 36'(wlog.size()), 36'd64);
        chk("b1_last", wl(63), {20'd63, 16'h7F7E});
        chk("b1_cnt", 36'(byte_cnt), 36'd128);
        chk("b1_blk", 36'(blk_num), 36'd1);

        // Bad block 2, then retransmit
        for (int i = 0; i < 7; i++) send(8'(8'hE0 + i), i == 0);
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(6);
        chk("inv_cnt", 36'(byte_cnt), 36'd128);
        wlog.delete();
        for (int i = 0; i < 128; i++) send(8'(8'h80 + i), i == 0);
        idle(6);
        chk("b2_nw", 36'(wlog.size()), 36'd64);
        chk("b2_first", wl(0), {20'd64, 16'h8180});
        chk("b2_last", wl(63), {20'd127, 16'hFFFE});
        chk("b2_cnt", 36'(byte_cnt), 36'd256);

        // Reset with three words queued
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 6; i++) send(8'(8'h30 + i), 1'b0);
        idle(2);
        chk("mr_we_pre", 36'(we), 36'd1);
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        #1;
        chk("mr_we", 36'(we), 36'd0);
        chk("mr_word", {addr, wdata}, 36'd0);
        chk("mr_cnt", 36'(byte_cnt), 36'd0);
        chk("mr_flags", 36'({blk_num, loaded, ovf}), 36'd0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        stall = 1'b0;
        idle(6);
        chk("mr_nw", 36'(wlog.size()), 36'd0);
        chk("mr_we_post", 36'(we), 36'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
